// File: rtl/interruption_controller_pkg.sv
// Shared types and default sizes for the task-clock interruption controller.
package interruption_controller_pkg;

    localparam int unsigned CNT_W_DEF  = 32;
    localparam int unsigned NUM_BP_DEF = 4;
    localparam int unsigned STEP_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Task clock is enabled only while running or stepping.
    function automatic logic ce_of(state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/interruption_controller_if.sv
// Host-side control/status bundle of the interruption controller.
interface interruption_controller_if
    import interruption_controller_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned NUM_BP = NUM_BP_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) ();

    logic                     run_en;
    logic                     clear;
    logic                     resume;
    logic                     step_req;
    logic [STEP_W-1:0]        step_count;
    logic                     ext_halt;
    logic [NUM_BP*CNT_W-1:0]  bp_value;
    logic [NUM_BP-1:0]        bp_enable;

    logic                     task_clk;
    logic                     task_clk_ce;
    logic [CNT_W-1:0]         cycle_count;
    logic                     halted;
    logic [NUM_BP-1:0]        bp_hit;
    logic                     ext_hit;
    logic                     overflow;
    logic [1:0]               state;

    modport master (
        output run_en, clear, resume, step_req, step_count, ext_halt, bp_value, bp_enable,
        input  task_clk, task_clk_ce, cycle_count, halted, bp_hit, ext_hit, overflow, state
    );

    modport slave (
        input  run_en, clear, resume, step_req, step_count, ext_halt, bp_value, bp_enable,
        output task_clk, task_clk_ce, cycle_count, halted, bp_hit, ext_hit, overflow, state
    );

endinterface

// File: rtl/interruption_controller_task_clk_gate.sv
// Glitch-free clock gate: BUFGCE on the FPGA, latch-based gate otherwise.
module task_clk_gate (
    input  logic clk_i,
    input  logic ce_i,
    output logic clk_o
);

`ifdef USE_BUFGCE
    BUFGCE u_bufgce (.I(clk_i), .CE(ce_i), .O(clk_o));
`else
    logic en_lat;

    // Enable is captured while the clock is low so the gated high phase is never cut short.
    always_latch begin
        if (!clk_i) en_lat <= ce_i;
    end

    assign clk_o = clk_i & en_lat;
`endif

endmodule

// File: rtl/interruption_controller.sv
// Gates the task clock, counts delivered edges and halts on breakpoints or external request.
module interruption_controller
    import interruption_controller_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned NUM_BP = NUM_BP_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic                      sys_clk,
    input  logic                      sys_reset_n,
    interruption_controller_if.slave  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [NUM_BP-1:0]   bp_hit_q, bp_hit_d, hit;
    logic                ext_hit_q, ext_hit_d;
    logic                ovf_q, ovf_d;
    logic                ce_q;
    logic                halted_q;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Comparators look at the count this cycle's edge will produce.
    for (genvar i = 0; i < int'(NUM_BP); i++) begin : g_bp
        assign hit[i] = ce_q & bus.bp_enable[i]
                      & (cnt_inc == bus.bp_value[i*CNT_W +: CNT_W]);
    end

    // State and status registers; ce and halted are decoded from next state so they are registered.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            step_q    <= '0;
            bp_hit_q  <= '0;
            ext_hit_q <= 1'b0;
            ovf_q     <= 1'b0;
            ce_q      <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            bp_hit_q  <= bp_hit_d;
            ext_hit_q <= ext_hit_d;
            ovf_q     <= ovf_d;
            ce_q      <= ce_of(state_d);
            halted_q  <= (state_d == ST_HALT);
        end
    end

    // Next-state logic; priority clear > ext_halt > bp hit > step done > run_en drop > resume/step.
    always_comb begin
        state_d   = state_q;
        cnt_d     = ce_q ? cnt_inc : cnt_q;
        step_d    = step_q;
        bp_hit_d  = bp_hit_q;
        ext_hit_d = ext_hit_q;
        ovf_d     = ovf_q | (ce_q & (&cnt_q));

        if (bus.clear) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            step_d    = '0;
            bp_hit_d  = '0;
            ext_hit_d = 1'b0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ext_halt) begin
                        state_d   = ST_HALT;
                        ext_hit_d = 1'b1;
                        bp_hit_d  = '0;
                    end else if (bus.run_en) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (state_q == ST_STEP) step_d = step_q - STEP_W'(1);
                    if (bus.ext_halt) begin
                        state_d   = ST_HALT;
                        ext_hit_d = 1'b1;
                        bp_hit_d  = '0;
                    end else if (|hit) begin
                        state_d   = ST_HALT;
                        bp_hit_d  = hit;
                        ext_hit_d = 1'b0;
                    end else if ((state_q == ST_STEP) && (step_q == STEP_W'(1))) begin
                        state_d = ST_HALT;
                    end else if ((state_q == ST_RUN) && !bus.run_en) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (bus.step_req && (bus.step_count != '0)) begin
                        state_d   = ST_STEP;
                        step_d    = bus.step_count;
                        bp_hit_d  = '0;
                        ext_hit_d = 1'b0;
                    end else if (bus.resume && bus.run_en) begin
                        state_d   = ST_RUN;
                        bp_hit_d  = '0;
                        ext_hit_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    task_clk_gate u_gate (
        .clk_i (sys_clk),
        .ce_i  (ce_q),
        .clk_o (bus.task_clk)
    );

    assign bus.task_clk_ce = ce_q;
    assign bus.cycle_count = cnt_q;
    assign bus.halted      = halted_q;
    assign bus.bp_hit      = bp_hit_q;
    assign bus.ext_hit     = ext_hit_q;
    assign bus.overflow    = ovf_q;
    assign bus.state       = state_q;

endmodule
